fsm_seq_alu_p: RTL
==================

Name: fsm_seq_alu_p

Overview:
- Parametrised, handshaked successor of the team's one-hot sequencer datapath.
- Accepts a start command with mode and shift amount, then loads two operands A and B over a valid/ready stream.
- Runs a mode-selected micro-op sequence on A, one micro-op per cycle.
- Returns A then B on a valid/ready output stream, with an overflow flag and a one-cycle done pulse.
- Sits between a command/operand source and a result sink in the processing pipeline.

Parameters:
- WIDTH, 8: operand, result and internal register width.
- SHIFT_W, 3: width of the shamt command field.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command request; sampled only in IDLE.
- mode  in  2  operation select; latched when start is accepted.
- shamt  in  SHIFT_W  shift count for SHL mode; latched when start is accepted.
- in_valid  in  1  operand valid.
- in_data  in  WIDTH  operand data.
- in_ready  out  1  operand ready.
- out_valid  out  1  result valid.
- out_data  out  WIDTH  result data.
- out_last  out  1  marks the second (final) result beat.
- out_ready  in  1  result sink ready.
- busy  out  1  high in every state except IDLE.
- ovf  out  WIDTH-independent 1  sticky overflow for the current operation.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: asynchronous and active-low; may assert in any state, including mid-operation.
  - Immediately forces state to IDLE and A, B, step counter, mode, shamt, ovf to 0.
  - Outputs in_ready, out_valid, out_data, out_last, busy, done all read 0.
- State encoding: one-hot, six states: IDLE, LOAD_A, LOAD_B, EXEC, OUT_A, OUT_B.
- IDLE: start=1 latches mode and shamt, clears ovf, and moves to LOAD_A. start in any other state is ignored and not queued.
- LOAD_A / LOAD_B:
  - in_ready=1 and decoded from state.
  - A transfer occurs when in_valid & in_ready.
  - In LOAD_A, a transfer writes A and moves to LOAD_B. In LOAD_B, a transfer writes B, sets step=0 and moves to EXEC.
  - With no transfer the state holds; there is no timeout.
- EXEC: in_ready=0. Each cycle applies one micro-op to A; B is never modified. All arithmetic wraps modulo 2^WIDTH.
  - mode 0 CHAIN, 3 cycles: A=A+B, then A=A-B, then A=A<<1. ovf |= carry from the add, borrow from the sub, and the MSB shifted out.
  - mode 1 ADD, 1 cycle: A=A+B; ovf = carry out.
  - mode 2 SUB, 1 cycle: A=A-B; ovf = borrow (A<B before the subtract).
  - mode 3 SHL: A=A<<1 repeated shamt times, max(shamt,1) cycles. When shamt=0, one idle EXEC cycle runs with A unchanged. ovf |= each MSB shifted out.
  - After the final micro-op cycle the state moves to OUT_A.
- OUT_A: out_valid=1, out_data=A, out_last=0. On out_ready the state moves to OUT_B.
- OUT_B: out_valid=1, out_data=B, out_last=1. On out_ready the state moves to IDLE and done=1 for exactly the next cycle (the first IDLE cycle).
- Output stability: while out_valid=1 and out_ready=0, out_data and out_last stay stable.
- Outside OUT_A/OUT_B: out_valid=0 and out_data=0.
- ovf remains valid and held from EXEC exit until the next accepted start.
- start in the done cycle is accepted normally, giving back-to-back operation.
- Latency with no stalls: start accepted at cycle 0 gives LOAD_A at 1, LOAD_B at 2, EXEC at 3.
  - First out_valid at cycle 3+E, where E is the number of EXEC cycles.
  - Minimum start-to-start spacing is 5+E cycles.

Decomposition:
- Shared package fsm_seq_pkg:
  - one-hot state localparams: 6 bits, IDLE=6'b000001 through OUT_B=6'b100000;
  - mode constants MODE_CHAIN=0, MODE_ADD=1, MODE_SUB=2, MODE_SHL=3;
  - the step counter width, sized to cover max(3, 2^SHIFT_W-1).
- Sub-module fsm_seq_alu_op is natural: a combinational micro-op unit. It takes A, B and an op select and returns next_A and an ovf_bit. The top module keeps the FSM, the registers and the handshakes.

Test Plan:
- CHAIN, A=0x10, B=0x05, no stalls -> EXEC lasts 3 cycles; out beats 0x20 (last=0) then 0x05 (last=1); ovf=0; done pulses once, the cycle after the final handshake.
- ADD, A=0xF0, B=0x20 -> out 0x10 then 0x20, ovf=1. SUB, A=0x03, B=0x05 -> out 0xFE, ovf=1. Then SUB, A=0x05, B=0x03 -> out 0x02, ovf=0, proving ovf clears on start.
- SHL, shamt=3, A=0x21 -> 3 EXEC cycles, out 0x08, ovf=1. SHL, shamt=0, A=0x21 -> 1 EXEC cycle, out 0x21, ovf=0.
- Backpressure: in_valid held low 2 cycles in each LOAD state, then out_ready held low 3 cycles in OUT_A -> states hold, out_data stays 0x20 throughout the stall, no beat is lost or duplicated. start pulsed during EXEC -> ignored, no extra operation.
- Back-to-back: start held high through done -> a second operation begins in the done cycle; busy goes low for exactly that one cycle.
- rst_n pulsed low during EXEC of CHAIN -> all outputs 0 immediately and state is IDLE. A subsequent ADD with A=0x01, B=0x01 -> out 0x02, ovf=0.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
// Shared types and constants for the handshaked sequencer datapath.
package fsm_seq_pkg;

  localparam int unsigned STATE_W = 6;

  // One-hot state encodings
  localparam logic [STATE_W-1:0] S_IDLE   = 6'b000001;
  localparam logic [STATE_W-1:0] S_LOAD_A = 6'b000010;
  localparam logic [STATE_W-1:0] S_LOAD_B = 6'b000100;
  localparam logic [STATE_W-1:0] S_EXEC   = 6'b001000;
  localparam logic [STATE_W-1:0] S_OUT_A  = 6'b010000;
  localparam logic [STATE_W-1:0] S_OUT_B  = 6'b100000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = S_IDLE,
    ST_LOAD_A = S_LOAD_A,
    ST_LOAD_B = S_LOAD_B,
    ST_EXEC   = S_EXEC,
    ST_OUT_A  = S_OUT_A,
    ST_OUT_B  = S_OUT_B
  } state_e;

  // Command modes
  localparam logic [1:0] MODE_CHAIN = 2'd0;
  localparam logic [1:0] MODE_ADD   = 2'd1;
  localparam logic [1:0] MODE_SUB   = 2'd2;
  localparam logic [1:0] MODE_SHL   = 2'd3;

  // Micro-op select for the combinational unit
  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2,
    OP_SHL = 2'd3
  } op_e;

  // Step counter width covering max(3, 2^shift_w - 1) EXEC cycles
  function automatic int unsigned step_w(input int unsigned shift_w);
    int unsigned max_steps;
    max_steps = (32'd1 << shift_w) - 32'd1;
    if (max_steps < 32'd3) max_steps = 32'd3;
    return int'($clog2(max_steps + 32'd1));
  endfunction

endpackage

// File: rtl/fsm_seq_alu_op.sv
// Combinational micro-op unit: one add, subtract or shift-left-by-one on A.
module fsm_seq_alu_op
  import fsm_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] next_a,
  output logic             ovf_bit
);

  logic [WIDTH:0] sum_c;

  // Select the micro-op result and its carry/borrow/shift-out bit
  always_comb begin
    next_a  = a;
    ovf_bit = 1'b0;
    sum_c   = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD: begin
        next_a  = sum_c[WIDTH-1:0];
        ovf_bit = sum_c[WIDTH];
      end
      OP_SUB: begin
        next_a  = a - b;
        ovf_bit = (a < b);
      end
      OP_SHL: begin
        next_a  = {a[WIDTH-2:0], 1'b0};
        ovf_bit = a[WIDTH-1];
      end
      default: begin
        next_a  = a;
        ovf_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fsm_seq_alu_p.sv
// Handshaked sequencer: load A/B, run a mode-selected micro-op sequence, stream A then B.
module fsm_seq_alu_p
  import fsm_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHIFT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHIFT_W-1:0] shamt,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic               busy,
  output logic               ovf,
  output logic               done
);

  localparam int unsigned STEP_W = step_w(SHIFT_W);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [1:0]         mode_q, mode_d;
  logic [SHIFT_W-1:0] shamt_q, shamt_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  op_e                op_c;
  logic [STEP_W-1:0]  last_step_c;
  logic [WIDTH-1:0]   alu_next_a;
  logic               alu_ovf;

  fsm_seq_alu_op #(
    .WIDTH (WIDTH)
  ) u_alu_op (
    .a       (a_q),
    .b       (b_q),
    .op      (op_c),
    .next_a  (alu_next_a),
    .ovf_bit (alu_ovf)
  );

  // Micro-op for the current EXEC step
  always_comb begin
    op_c = OP_NOP;
    if (state_q == ST_EXEC) begin
      case (mode_q)
        MODE_CHAIN: begin
          if (step_q == STEP_W'(0))      op_c = OP_ADD;
          else if (step_q == STEP_W'(1)) op_c = OP_SUB;
          else                           op_c = OP_SHL;
        end
        MODE_ADD: op_c = OP_ADD;
        MODE_SUB: op_c = OP_SUB;
        default:  op_c = (shamt_q == SHIFT_W'(0)) ? OP_NOP : OP_SHL;
      endcase
    end
  end

  // Index of the final EXEC step; SHL with zero shift still spends one cycle
  always_comb begin
    last_step_c = STEP_W'(0);
    case (mode_q)
      MODE_CHAIN: last_step_c = STEP_W'(2);
      MODE_ADD:   last_step_c = STEP_W'(0);
      MODE_SUB:   last_step_c = STEP_W'(0);
      default: begin
        if (shamt_q == SHIFT_W'(0)) last_step_c = STEP_W'(0);
        else                        last_step_c = STEP_W'(shamt_q - SHIFT_W'(1));
      end
    endcase
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    step_d  = step_q;
    mode_d  = mode_q;
    shamt_d = shamt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          shamt_d = shamt;
          ovf_d   = 1'b0;
          state_d = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        if (in_valid && in_ready_q) begin
          a_d     = in_data;
          state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (in_valid && in_ready_q) begin
          b_d     = in_data;
          step_d  = STEP_W'(0);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        a_d    = alu_next_a;
        ovf_d  = ovf_q | alu_ovf;
        step_d = step_q + STEP_W'(1);
        if (step_q == last_step_c) state_d = ST_OUT_A;
      end
      ST_OUT_A: begin
        if (out_ready) state_d = ST_OUT_B;
      end
      ST_OUT_B: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so decode them from the next state
    in_ready_d  = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
    out_valid_d = (state_d == ST_OUT_A) || (state_d == ST_OUT_B);
    out_last_d  = (state_d == ST_OUT_B);
    busy_d      = (state_d != ST_IDLE);
    if (state_d == ST_OUT_A)      out_data_d = a_d;
    else if (state_d == ST_OUT_B) out_data_d = b_d;
    else                          out_data_d = '0;
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      step_q      <= '0;
      mode_q      <= '0;
      shamt_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      step_q      <= step_d;
      mode_q      <= mode_d;
      shamt_q     <= shamt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign done      = done_q;

endmodule
